// File: rtl/fp_mac_issue_ctrl_pkg.sv
// Shared types and constants for the FP MAC issue/hazard controller.
// Holds the FSM state encoding, the default pipeline depth and the tag record width.
package fp_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int CYCLE_DEF   = 8;
    localparam int NUM_ACC_DEF = 4;

    // Tag record per pipeline stage: {vld, last, zero, id}
    localparam int TAG_FLAGS_W = 3;

    function automatic int tag_rec_w(input int acc_w);
        return acc_w + TAG_FLAGS_W;
    endfunction

endpackage

// File: rtl/fp_mac_issue_ctrl_if.sv
// Op handshake, issue and write-back signals of the FP MAC issue controller.
// master = op source / datapath side, slave = controller.
interface fp_mac_issue_ctrl_if #(
    parameter int ACC_W = 2
);
    logic             in_valid;
    logic [ACC_W-1:0] in_acc_id;
    logic             in_first;
    logic             in_last;
    logic             in_ready;
    logic             issue_valid;
    logic [ACC_W-1:0] issue_acc_id;
    logic             issue_zero;
    logic             acc_we;
    logic [ACC_W-1:0] acc_we_id;
    logic             out_valid;

    modport master (
        output in_valid, in_acc_id, in_first, in_last,
        input  in_ready, issue_valid, issue_acc_id, issue_zero,
               acc_we, acc_we_id, out_valid
    );

    modport slave (
        input  in_valid, in_acc_id, in_first, in_last,
        output in_ready, issue_valid, issue_acc_id, issue_zero,
               acc_we, acc_we_id, out_valid
    );
endinterface

// File: rtl/fp_mac_issue_ctrl_tag_stage.sv
// One stage of the op tracking shift register (vld/last/zero/id), aligned with
// one adder pipeline stage. No enable: the datapath pipeline never stalls.
module fp_mac_tag_stage #(
    parameter int TW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [TW-1:0] d,
    output logic [TW-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/fp_mac_issue_ctrl.sv
// Issue/hazard controller for the FP MAC accumulate loop: one op per clock, RAW stall per accumulator.
// Optional statistics counters are enabled by defining FP_MAC_ISSUE_STATS_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | not accepting; waits for start
// ST_RUN   | accepting ops, hazard-checked against every tracked stage
// ST_DRAIN | flush seen; no accepts, in-flight ops retire, done at empty
module fp_mac_issue_ctrl
    import fp_mac_pkg::*;
#(
    parameter int CYCLE   = CYCLE_DEF,
    parameter int NUM_ACC = NUM_ACC_DEF,
    parameter int ACC_W   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    fp_mac_issue_ctrl_if.slave     bus,
    input  logic                   start,
    input  logic                   flush,
    output logic                   busy,
    output logic                   done
`ifdef FP_MAC_ISSUE_STATS_EN
   ,output logic [31:0]            stat_issued
   ,output logic [31:0]            stat_stall
`endif
);

    localparam int TW  = tag_rec_w(ACC_W);
    localparam int V_B = TW - 1;
    localparam int L_B = TW - 2;
    localparam int Z_B = TW - 3;
    localparam int IW  = $clog2(CYCLE + 1);

    // Ids above NUM_ACC-1 alias onto the implemented contexts.
    localparam logic [ACC_W-1:0] ID_MASK = ACC_W'(NUM_ACC - 1);

    state_t state_q, state_d;

    logic [TW-1:0]    tag_d [CYCLE];
    logic [TW-1:0]    tag_q [CYCLE];
    logic [CYCLE-1:0] vld;
    logic [CYCLE-1:0] lst;
    logic [CYCLE-1:0] zro;
    logic [ACC_W-1:0] idv [CYCLE];

    logic [ACC_W-1:0] in_id;
    logic             hz;
    logic             accept;
    logic [IW-1:0]    inflight;

    assign in_id = bus.in_acc_id & ID_MASK;

    genvar k;
    generate
        for (k = 0; k < CYCLE; k++) begin : g_stage
            fp_mac_tag_stage #(.TW(TW)) u_stage (
                .clock (clock),
                .reset (reset),
                .d     (tag_d[k]),
                .q     (tag_q[k])
            );
            assign vld[k] = tag_q[k][V_B];
            assign lst[k] = tag_q[k][L_B];
            assign zro[k] = tag_q[k][Z_B];
            assign idv[k] = tag_q[k][ACC_W-1:0];
            if (k == 0) begin : g_head
                assign tag_d[k] = accept ? {1'b1, bus.in_last, bus.in_first, in_id} : '0;
            end else begin : g_body
                assign tag_d[k] = tag_q[k-1];
            end
        end
    endgenerate

    // The retiring stage is included: its write-back lands on the same edge a new read would sample.
    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < CYCLE; i++) begin
            if (vld[i] && (idv[i] == in_id)) begin
                hz = 1'b1;
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < CYCLE; i++) begin
            inflight = inflight + IW'(vld[i]);
        end
    end

    assign bus.in_ready = (state_q == ST_RUN) && !hz;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE) || (inflight != '0);

    assign bus.issue_valid  = vld[0];
    assign bus.issue_acc_id = idv[0];
    assign bus.issue_zero   = zro[0];

    assign bus.acc_we    = vld[CYCLE-1];
    assign bus.acc_we_id = idv[CYCLE-1];
    assign bus.out_valid = vld[CYCLE-1] && lst[CYCLE-1];

`ifdef FP_MAC_ISSUE_STATS_EN
    logic stall_cyc;
    assign stall_cyc = bus.in_valid && (state_q == ST_RUN) && hz;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (accept && (stat_issued != '1)) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (stall_cyc && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_mac_issue_ctrl.sv
// Directed bench for fp_mac_issue_ctrl (CYCLE=8, NUM_ACC=4) with issue/retire scoreboards.
// Statistics checks are compiled in when FP_MAC_ISSUE_STATS_EN is defined.
module tb_fp_mac_issue_ctrl;
    import fp_mac_pkg::*;

    localparam int CYC = 8;

    typedef struct packed {
        logic [1:0]  id;
        logic        first;
        logic        last;
        logic [31:0] due;
    } rec_t;

    logic clock;
    logic reset;
    logic start;
    logic flush;
    logic busy;
    logic done;
`ifdef FP_MAC_ISSUE_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;
`endif

    fp_mac_issue_ctrl_if #(.ACC_W(2)) bus ();

    fp_mac_issue_ctrl #(.CYCLE(CYC), .NUM_ACC(4), .ACC_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .start (start),
        .flush (flush),
        .busy  (busy),
        .done  (done)
`ifdef FP_MAC_ISSUE_STATS_EN
       ,.stat_issued (stat_issued)
       ,.stat_stall  (stat_stall)
`endif
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   iss_cnt = 0;
    int   ov_cnt = 0;
    int   done_cnt = 0;
    rec_t acc_q[$];
    rec_t iss_q[$];
    rec_t mon_e;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.issue_valid) begin
                iss_cnt++;
                chk("issue_expected", 32'(iss_q.size() > 0), 32'd1);
                if (iss_q.size() > 0) begin
                    mon_e = iss_q.pop_front();
                    chk("issue_id", 32'(bus.issue_acc_id), 32'(mon_e.id));
                    chk("issue_zero", 32'(bus.issue_zero), 32'(mon_e.first));
                    chk("issue_cycle", cyc, mon_e.due);
                end
            end
            if (bus.acc_we) begin
                acc_cnt++;
                chk("acc_we_expected", 32'(acc_q.size() > 0), 32'd1);
                if (acc_q.size() > 0) begin
                    mon_e = acc_q.pop_front();
                    chk("acc_we_id", 32'(bus.acc_we_id), 32'(mon_e.id));
                    chk("out_valid_last", 32'(bus.out_valid), 32'(mon_e.last));
                    chk("acc_we_cycle", cyc, mon_e.due);
                end
            end
            if (bus.out_valid) begin
                ov_cnt++;
                chk("out_valid_needs_we", 32'(bus.acc_we), 32'd1);
            end
            if (done) done_cnt++;
        end
    end

    task automatic drive_op(input logic [1:0] id, input logic first, input logic last,
                            input logic fl, output int acc);
        bus.in_valid  = 1'b1;
        bus.in_acc_id = id;
        bus.in_first  = first;
        bus.in_last   = last;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                acc = cyc;
                acc_q.push_back('{id: id, first: first, last: last, due: 32'(cyc + CYC)});
                iss_q.push_back('{id: id, first: first, last: last, due: 32'(cyc + 1)});
                if (fl) flush = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 32'(acc >= 0), 32'd1);
        @(posedge clock);
        #1;
        flush = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while ((acc_q.size() != 0 || iss_q.size() != 0) && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("drain_timeout", 32'(acc_q.size() + iss_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    int t0, t1, t2, a0, a1, a2, a3, a4, f0, f1, f2, f3, dc;
    int acc_b, ov_b, done_b;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_acc_id = 2'd0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_acc_we", 32'(bus.acc_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        chk("idle_ready", 32'(bus.in_ready), 32'd0);

        // Single sum
        start_pulse();
        chk("run_busy", 32'(busy), 32'd1);
        acc_b = acc_cnt; ov_b = ov_cnt;
        drive_op(2'd1, 1'b1, 1'b1, 1'b0, t0);
        idle();
        wait_empty(20);
        chk("single_acc_cnt", acc_cnt - acc_b, 1);
        chk("single_ov_cnt", ov_cnt - ov_b, 1);

        // Same-id chain
        acc_b = acc_cnt; ov_b = ov_cnt;
        drive_op(2'd0, 1'b1, 1'b0, 1'b0, t0);
        drive_op(2'd0, 1'b0, 1'b0, 1'b0, t1);
        drive_op(2'd0, 1'b0, 1'b1, 1'b0, t2);
        idle();
        chk("chain_gap1", t1 - t0, 9);
        chk("chain_gap2", t2 - t0, 18);
        wait_empty(20);
        chk("chain_acc_cnt", acc_cnt - acc_b, 3);
        chk("chain_ov_cnt", ov_cnt - ov_b, 1);

        // Flush with nothing in flight
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        chk("empty_flush_done", 32'(done), 32'd1);
        @(posedge clock);
        #1;
        chk("empty_flush_busy", 32'(busy), 32'd0);

        // Rotating ids, then a repeat of id 0
        start_pulse();
        drive_op(2'd0, 1'b1, 1'b0, 1'b0, a0);
        drive_op(2'd1, 1'b1, 1'b0, 1'b0, a1);
        drive_op(2'd2, 1'b1, 1'b0, 1'b0, a2);
        drive_op(2'd3, 1'b1, 1'b1, 1'b0, a3);
        drive_op(2'd0, 1'b0, 1'b1, 1'b0, a4);
        idle();
        chk("rot_gap1", a1 - a0, 1);
        chk("rot_gap2", a2 - a0, 2);
        chk("rot_gap3", a3 - a0, 3);
        chk("rot_repeat", a4 - a0, 9);
`ifdef FP_MAC_ISSUE_STATS_EN
        chk("stat_issued", stat_issued, 32'd5);
        chk("stat_stall", stat_stall, 32'd5);
`endif
        wait_empty(20);

        // Offer id 2 exactly while id 2 retires
        drive_op(2'd2, 1'b1, 1'b1, 1'b0, t0);
        idle();
        while (cyc < t0 + CYC) begin
            @(posedge clock);
            #1;
        end
        bus.in_valid  = 1'b1;
        bus.in_acc_id = 2'd2;
        @(negedge clock);
        chk("retire_edge_we", 32'(bus.acc_we), 32'd1);
        chk("retire_edge_ready", 32'(bus.in_ready), 32'd0);
        drive_op(2'd2, 1'b1, 1'b1, 1'b0, t1);
        idle();
        chk("retire_edge_accept", t1 - t0, 9);
        wait_empty(20);

        // Flush together with the last of four in-flight ops
        acc_b = acc_cnt; done_b = done_cnt;
        drive_op(2'd0, 1'b1, 1'b1, 1'b0, f0);
        drive_op(2'd1, 1'b1, 1'b1, 1'b0, f1);
        drive_op(2'd2, 1'b1, 1'b1, 1'b0, f2);
        drive_op(2'd3, 1'b1, 1'b1, 1'b1, f3);
        idle();
        @(negedge clock);
        chk("drain_ready", 32'(bus.in_ready), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        dc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        chk("drain_done_cycle", dc - f0, 12);
        @(posedge clock);
        #1;
        chk("drain_acc_cnt", acc_cnt - acc_b, 4);
        chk("drain_done_cnt", done_cnt - done_b, 1);
        chk("drain_idle_busy", 32'(busy), 32'd0);
        chk("drain_idle_ready", 32'(bus.in_ready), 32'd0);

        // Reset with three ops in flight
        start_pulse();
        drive_op(2'd0, 1'b1, 1'b1, 1'b0, t0);
        drive_op(2'd1, 1'b1, 1'b1, 1'b0, t1);
        drive_op(2'd2, 1'b1, 1'b1, 1'b0, t2);
        idle();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_issue", 32'(bus.issue_valid), 32'd0);
        chk("mid_rst_acc_we", 32'(bus.acc_we), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        acc_q.delete();
        iss_q.delete();
        acc_b = acc_cnt;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("post_rst_no_acc", acc_cnt - acc_b, 0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
